// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Serial program loader. Receives an 8N1 byte stream on rx and writes it as
// 32-bit little-endian words into instruction memory while holding the CPU in
// reset. Frame format: 0xA5 header, word count N (1..255), N*4 data bytes,
// and optionally one XOR checksum byte.
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to expect and verify a
// trailing checksum byte (XOR of all data bytes). Undefined: no checksum
// state or logic; the load completes right after the Nth word write.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit
//   ADDR_W        width of the memory word address
//   TIMEOUT_BITS  inter-byte idle limit, in bit periods
//
// Ports
//   clock         sole clock, rising edge
//   reset         asynchronous, active-high reset
//   rx            serial input, idle high, LSB first
//   mem_we        one-cycle word write strobe
//   mem_addr      word address of the current write
//   mem_wdata     word to write
//   cpu_hold      high while a load is in progress
//   busy          high whenever the loader FSM is not idle
//   done          one-cycle pulse on successful completion
//   error         sticky load-failure flag (cleared by the next header)
//   words_loaded  number of words written by the last or current load
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam int HALF_BIT   = CLKS_PER_BIT / 2;
    localparam int CNT_W      = $clog2(CLKS_PER_BIT + 1);
    localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       rx_byte;

    // The shift register keeps the last byte until the next start bit, so it
    // is still stable in the cycle byte_valid is high.
    assign rx_byte = shift_q;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver next-state: bit timing, sampling and byte/framing strobes.
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = 3'd0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                // Mid-start-bit recheck filters out glitches on the line.
                if (clk_cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    clk_cnt_d = '0;
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                clk_cnt_d  = '0;
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } ld_state_t;

    // Running checksum step: XOR of all data bytes.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic [7:0] csum_q, csum_d;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } ld_state_t;
`endif

    ld_state_t         state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic [7:0]        left_q, left_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              tmo_expired;
    logic              load_fail;

    assign tmo_expired = (tmo_q == TMO_W'(TMO_CYCLES - 1));
    // A load aborts on a framing error, or on idle-timeout when no byte
    // arrived in this cycle (a fresh byte always restarts the timer).
    assign load_fail   = frame_err_q || (!byte_valid_q && tmo_expired);

    // Loader next-state and registered-output values.
    always_comb begin
        state_d    = state_q;
        mem_we_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = 1'b0;
        error_d    = error_q;
        words_d    = words_q;
        left_d     = left_q;
        byte_idx_d = byte_idx_q;
        tmo_d      = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (byte_valid_q && (rx_byte == 8'hA5)) begin
                    state_d    = ST_COUNT;
                    cpu_hold_d = 1'b1;
                    error_d    = 1'b0;
                    words_d    = '0;
                    addr_d     = '0;
                    byte_idx_d = 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (load_fail || (byte_valid_q && (rx_byte == 8'h00))) begin
                    state_d    = ST_ERR;
                    error_d    = 1'b1;
                    cpu_hold_d = 1'b0;
                end else if (byte_valid_q) begin
                    left_d  = rx_byte;
                    state_d = ST_DATA;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DATA: begin
                if (mem_we_q) begin
                    // Write cycle: advance address/count for the next word.
                    addr_d  = addr_q + ADDR_W'(1);
                    words_d = words_q + ADDR_W'(1);
                    left_d  = left_q - 8'd1;
                    tmo_d   = tmo_q + TMO_W'(1);
                    if (left_q == 8'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d    = ST_CSUM;
`else
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (load_fail) begin
                    state_d    = ST_ERR;
                    error_d    = 1'b1;
                    cpu_hold_d = 1'b0;
                end else if (byte_valid_q) begin
                    // Shift in from the top so the first byte ends in [7:0].
                    wdata_d = {rx_byte, wdata_q[31:8]};
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_next(csum_q, rx_byte);
`endif
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d   = 1'b1;
                        byte_idx_d = 2'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (load_fail || (byte_valid_q && (rx_byte != csum_q))) begin
                    state_d    = ST_ERR;
                    error_d    = 1'b1;
                    cpu_hold_d = 1'b0;
                end else if (byte_valid_q) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                cpu_hold_d = 1'b0;
            end
        endcase
    end

    // Loader state and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0000_0000;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            left_q     <= 8'h00;
            byte_idx_q <= 2'd0;
            tmo_q      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= done_d;
            error_q    <= error_d;
            words_q    <= words_d;
            left_q     <= left_d;
            byte_idx_q <= byte_idx_d;
            tmo_q      <= tmo_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 The module SHALL have parameter ADDR_W, default 8, width of the memory word address.
REQ-003 The module SHALL have parameter TIMEOUT_BITS, default 64, inter-byte idle limit in bit periods.
REQ-004 clock  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 mem_we  output  1  one-cycle word write strobe to instruction memory.
REQ-008 mem_addr  output  ADDR_W  word address of the current write.
REQ-009 mem_wdata  output  32  word to write.
REQ-010 cpu_hold  output  1  high while a load is in progress; holds the processor in reset.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse on successful load completion.
REQ-013 error  output  1  sticky load-failure flag.
REQ-014 words_loaded  output  ADDR_W  number of words written by the last or current load.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer before use.
REQ-016 Receiver: a falling edge starts a byte; start bit re-checked at CLKS_PER_BIT/2; if it is high, the receiver aborts silently to idle; data bits sampled at the centre of each bit period.
REQ-017 Receiver: stop bit sampled low -> framing error; byte discarded.
REQ-018 Receiver SHALL emit an internal one-cycle byte_valid with the byte, one cycle after the stop-bit sample.
REQ-019 FSM states: IDLE, COUNT, DATA, CSUM, DONE, ERR.
REQ-020 IDLE: byte 0xA5 -> COUNT, cpu_hold=1, error=0, words_loaded=0, mem_addr=0; any other byte is ignored.
REQ-021 COUNT: the byte is the word count N; N=0 -> ERR; else latch N -> DATA.
REQ-022 DATA: bytes are assembled little-endian into mem_wdata; on the 4th byte, mem_we=1 in the next cycle with the current mem_addr and the full word.
REQ-023 After each write, mem_addr and words_loaded SHALL increment by 1; mem_addr wraps modulo 2^ADDR_W.
REQ-024 After the Nth write -> CSUM (checksum enabled) or DONE (disabled).
REQ-025 DONE: done=1 for exactly one cycle, cpu_hold=0 in that same cycle -> IDLE.
REQ-026 ERR: cpu_hold=0, error=1 (held until the next accepted 0xA5 header) -> IDLE in the next cycle.
REQ-027 Framing error in COUNT/DATA/CSUM -> ERR; in IDLE -> ignored.
REQ-028 Timeout: in COUNT/DATA/CSUM, no byte_valid for TIMEOUT_BITS*CLKS_PER_BIT cycles -> ERR; the counter restarts on every byte_valid.
REQ-029 Words already written before an error SHALL remain written; no rollback.
REQ-030 mem_we SHALL never be asserted outside DATA.
REQ-031 busy = (state != IDLE); cpu_hold SHALL be high from the cycle after the header byte_valid until DONE or ERR.

Reset
REQ-032 Reset SHALL force state=IDLE, receiver idle, synchronizer flops=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, words_loaded=0, counters=0.
REQ-033 Reset asserted mid-load SHALL abort immediately, release cpu_hold, issue no further write, and report no error.

Configuration
REQ-034 Macro PROG_LOADER_CHECKSUM_EN defined: after the data, a CSUM byte equal to the XOR of all N*4 data bytes SHALL be expected; match -> DONE; mismatch -> ERR.
REQ-035 PROG_LOADER_CHECKSUM_EN undefined: no CSUM state or XOR logic; DATA -> DONE directly after the Nth write.

Verification
REQ-036 Bench SHALL cover: A5 01 78 56 34 12 [08] -> one mem_we at addr 0, data 0x12345678, done pulse, words_loaded=1, error=0.
REQ-037 Bench SHALL cover: A5 02 + 8 bytes 00..07 [csum 00] -> writes 0x03020100 at addr 0 and 0x07060504 at addr 1, done pulse.
REQ-038 Bench SHALL cover (checksum enabled): A5 01 01 00 00 00 FF -> one write, then ERR, error=1, no done pulse, cpu_hold=0.
REQ-039 Bench SHALL cover: A5 00 -> ERR with no mem_we; a following 3C is ignored; a following valid A5 01 ... load clears error.
REQ-040 Bench SHALL cover: A5 01 11 22 then silence > 64 bit periods -> ERR, error=1, no write.
REQ-041 Bench SHALL cover: reset pulse after the 2nd data byte -> all outputs at reset values; a subsequent full load succeeds.
